// File: rtl/mcu_spi_bridge.sv
// SPI mode-0 slave linking the companion MCU to the on-FPGA control targets.
// The first byte of a transaction selects a target, later bytes are strobed to it and its reply is shifted back.
module mcu_spi_bridge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_ss_n,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       mcu_start,
    output logic [7:0] mcu_dout,
    output logic       mcu_sys_strobe,
    output logic       mcu_hid_strobe,
    output logic       mcu_osd_strobe,
    output logic       mcu_sdc_strobe,
    input  logic [7:0] mcu_sys_din,
    input  logic [7:0] mcu_hid_din,
    input  logic [7:0] mcu_osd_din,
    input  logic [7:0] mcu_sdc_din
);

    typedef enum logic [1:0] {IDLE, TARGET, DATA} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
    logic       ss_s, sclk_s, mosi_s;
    logic       ss_prev, sclk_prev;
    logic       sclk_rise, sclk_fall, ss_fall;
    logic       active, byte_done, target_ok;
    logic [2:0] bit_cnt;
    logic [7:0] rx, rx_byte, tx, target, reply;
    logic       first;
    logic [3:0] strobe;
    logic [1:0] load_pend;
    logic       load_valid;

    // ss_n synchroniser and ss_prev reset low: a chip select already low at reset
    // never shows a falling edge until the MCU releases it once.
    always_ff @(posedge clk) begin
        if (reset) begin
            ss_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_prev   <= 1'b0;
            sclk_prev <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            ss_prev   <= ss_s;
            sclk_prev <= sclk_s;
        end
    end

    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign ss_fall   = ss_prev & ~ss_s;
    assign active    = (state != IDLE) && !ss_s;
    assign byte_done = active && sclk_rise && (bit_cnt == 3'd7);
    assign rx_byte   = {rx[6:0], mosi_s};
    assign target_ok = (target[7:2] == 6'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ss_fall) state_next = TARGET;
            TARGET:  if (ss_s) state_next = IDLE;
                     else if (byte_done) state_next = DATA;
            DATA:    if (ss_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        reply = 8'h00;
        if (load_valid) begin
            case (target[1:0])
                2'd0: reply = mcu_sys_din;
                2'd1: reply = mcu_hid_din;
                2'd2: reply = mcu_osd_din;
                2'd3: reply = mcu_sdc_din;
            endcase
        end
    end

    // The falling edge that closes a byte does not shift: the reply loaded just before
    // it already presents its MSB for the first rising edge of the next byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= '0;
            rx         <= '0;
            tx         <= '0;
            target     <= '0;
            first      <= 1'b0;
            strobe     <= '0;
            mcu_start  <= 1'b0;
            mcu_dout   <= '0;
            load_pend  <= '0;
            load_valid <= 1'b0;
        end else begin
            strobe    <= '0;
            mcu_start <= 1'b0;
            mcu_dout  <= '0;
            load_pend <= {load_pend[0] & ~ss_s, byte_done};

            if (!active) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                rx      <= rx_byte;
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (byte_done) begin
                if (state == TARGET) begin
                    target     <= rx_byte;
                    first      <= 1'b1;
                    load_valid <= 1'b0;
                end else begin
                    load_valid <= target_ok;
                    first      <= 1'b0;
                    if (target_ok) begin
                        strobe[target[1:0]] <= 1'b1;
                        mcu_start           <= first;
                        mcu_dout            <= rx_byte;
                    end
                end
            end

            if (ss_fall) begin
                tx <= '0;
            end else if (load_pend[1] && !ss_s) begin
                tx <= reply;
            end else if (active && sclk_fall && (bit_cnt != 3'd0)) begin
                tx <= {tx[6:0], 1'b0};
            end
        end
    end

    assign mcu_sys_strobe = strobe[0];
    assign mcu_hid_strobe = strobe[1];
    assign mcu_osd_strobe = strobe[2];
    assign mcu_sdc_strobe = strobe[3];
    assign spi_miso       = ~ss_s & tx[7];

endmodule

// File: tb/tb_mcu_spi_bridge.sv
// Directed testbench for mcu_spi_bridge: an MCU-side SPI master drives byte vectors,
// a strobe monitor and simple target reply models supply the observed and expected traffic.
module tb_mcu_spi_bridge;

    logic       clk;
    logic       reset;
    logic       spi_ss_n, spi_sclk, spi_mosi, spi_miso;
    logic       mcu_start;
    logic [7:0] mcu_dout;
    logic       mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_sdc_strobe;
    logic [7:0] mcu_sys_din, mcu_hid_din, mcu_osd_din, mcu_sdc_din;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic       new_txn;
        int         half;
        logic [7:0] mosi;
        logic [7:0] miso_exp;
        logic [3:0] strobe_exp;
        logic       start_exp;
        logic [7:0] dout_exp;
    } vec_t;

    vec_t vecs [15];

    mcu_spi_bridge #(.SYNC_STAGES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .spi_ss_n       (spi_ss_n),
        .spi_sclk       (spi_sclk),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .mcu_start      (mcu_start),
        .mcu_dout       (mcu_dout),
        .mcu_sys_strobe (mcu_sys_strobe),
        .mcu_hid_strobe (mcu_hid_strobe),
        .mcu_osd_strobe (mcu_osd_strobe),
        .mcu_sdc_strobe (mcu_sdc_strobe),
        .mcu_sys_din    (mcu_sys_din),
        .mcu_hid_din    (mcu_hid_din),
        .mcu_osd_din    (mcu_osd_din),
        .mcu_sdc_din    (mcu_sdc_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // System-control target: registers the next reply from its table on every strobe.
    int sys_idx = 0;

    function automatic logic [7:0] sys_reply(input int k);
        case (k)
            0:       return 8'h5C;
            1:       return 8'h42;
            2:       return 8'h00;
            3:       return 8'h11;
            4:       return 8'hD2;
            default: return 8'hE1;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mcu_sys_din <= 8'h00;
        end else if (mcu_sys_strobe) begin
            mcu_sys_din <= sys_reply(sys_idx);
            sys_idx     <= sys_idx + 1;
        end
    end

    logic [3:0] strobes;
    assign strobes = {mcu_sdc_strobe, mcu_osd_strobe, mcu_hid_strobe, mcu_sys_strobe};

    int         strobe_cycles = 0;
    int         stray_cycles  = 0;
    int         tgt_cnt [4]   = '{0, 0, 0, 0};
    logic       last_start    = 1'b0;
    logic [7:0] last_dout     = 8'h00;

    always @(negedge clk) begin
        if (strobes != 4'b0000) begin
            strobe_cycles <= strobe_cycles + 1;
            for (int t = 0; t < 4; t++) begin
                if (strobes[t]) tgt_cnt[t] <= tgt_cnt[t] + 1;
            end
            last_start <= mcu_start;
            last_dout  <= mcu_dout;
        end else if (mcu_start || (mcu_dout != 8'h00)) begin
            stray_cycles <= stray_cycles + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic n, input int h, input logic [7:0] m, input logic [7:0] mi,
                                input logic [3:0] s, input logic st, input logic [7:0] d);
        vec_t v;
        v.new_txn    = n;
        v.half       = h;
        v.mosi       = m;
        v.miso_exp   = mi;
        v.strobe_exp = s;
        v.start_exp  = st;
        v.dout_exp   = d;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic ss_cycle();
        @(negedge clk);
        spi_ss_n = 1'b1;
        repeat (8) @(negedge clk);
        spi_ss_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Mode 0, MSB first: mosi set while sclk low, miso sampled just before each rising edge.
    task automatic send_bits(input logic [7:0] val, input int nbits, input int half, output logic [7:0] rx);
        rx = 8'h00;
        @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = val[7-i];
            repeat (half) @(negedge clk);
            rx[7-i]  = spi_miso;
            spi_sclk = 1'b1;
            repeat (half) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int         c0, s0, dc;
        int         t0 [4];
        logic [7:0] rx;
        logic [3:0] mask;
        logic       st;
        logic [7:0] dd;
        if (v.new_txn) ss_cycle();
        c0 = strobe_cycles;
        s0 = stray_cycles;
        for (int t = 0; t < 4; t++) t0[t] = tgt_cnt[t];
        send_bits(v.mosi, 8, v.half, rx);
        dc = strobe_cycles - c0;
        for (int t = 0; t < 4; t++) mask[t] = (tgt_cnt[t] != t0[t]);
        st = (dc > 0) ? last_start : 1'b0;
        dd = (dc > 0) ? last_dout : 8'h00;
        checkOutput({tag, " miso"},   32'(rx),   32'(v.miso_exp));
        checkOutput({tag, " strobe"}, 32'(mask), 32'(v.strobe_exp));
        checkOutput({tag, " pulses"}, 32'(dc),   (v.strobe_exp != 4'b0000) ? 32'd1 : 32'd0);
        checkOutput({tag, " start"},  32'(st),   32'(v.start_exp));
        checkOutput({tag, " dout"},   32'(dd),   32'(v.dout_exp));
        checkOutput({tag, " stray"},  32'(stray_cycles - s0), 32'd0);
    endtask

    initial begin
        logic [7:0] rx;
        int         c0;

        reset       = 1'b1;
        spi_ss_n    = 1'b1;
        spi_sclk    = 1'b0;
        spi_mosi    = 1'b0;
        mcu_hid_din = 8'h69;
        mcu_osd_din = 8'hE7;
        mcu_sdc_din = 8'h3C;

        // Target 0 with reply chain, invalid target 7, minimum sclk phase on target 3, then OSD.
        vecs[0]  = mk(1'b1, 7, 8'h00, 8'h00, 4'b0000, 1'b0, 8'h00);
        vecs[1]  = mk(1'b0, 7, 8'h00, 8'h00, 4'b0001, 1'b1, 8'h00);
        vecs[2]  = mk(1'b0, 7, 8'hAA, 8'h5C, 4'b0001, 1'b0, 8'hAA);
        vecs[3]  = mk(1'b0, 7, 8'hBB, 8'h42, 4'b0001, 1'b0, 8'hBB);
        vecs[4]  = mk(1'b0, 7, 8'hCC, 8'h00, 4'b0001, 1'b0, 8'hCC);
        vecs[5]  = mk(1'b1, 6, 8'h07, 8'h00, 4'b0000, 1'b0, 8'h00);
        vecs[6]  = mk(1'b0, 6, 8'hDE, 8'h00, 4'b0000, 1'b0, 8'h00);
        vecs[7]  = mk(1'b0, 6, 8'hAD, 8'h00, 4'b0000, 1'b0, 8'h00);
        vecs[8]  = mk(1'b0, 6, 8'hFF, 8'h00, 4'b0000, 1'b0, 8'h00);
        vecs[9]  = mk(1'b1, 5, 8'h03, 8'h00, 4'b0000, 1'b0, 8'h00);
        vecs[10] = mk(1'b0, 5, 8'h81, 8'h00, 4'b1000, 1'b1, 8'h81);
        vecs[11] = mk(1'b0, 5, 8'h00, 8'h3C, 4'b1000, 1'b0, 8'h00);
        vecs[12] = mk(1'b1, 7, 8'h02, 8'h00, 4'b0000, 1'b0, 8'h00);
        vecs[13] = mk(1'b0, 7, 8'h12, 8'h00, 4'b0100, 1'b1, 8'h12);
        vecs[14] = mk(1'b0, 7, 8'h34, 8'hE7, 4'b0100, 1'b0, 8'h34);

        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset miso",    32'(spi_miso),  32'd0);
        checkOutput("reset start",   32'(mcu_start), 32'd0);
        checkOutput("reset dout",    32'(mcu_dout),  32'd0);
        checkOutput("reset strobes", 32'(strobes),   32'd0);

        for (int i = 0; i < 15; i++) applyStimulus(vecs[i], $sformatf("v%0d", i));

        // OSD reply 0xE7 is now loaded: its MSB shows while selected and is gated off after release.
        @(negedge clk);
        checkOutput("miso selected", 32'(spi_miso), 32'd1);
        spi_ss_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("miso released", 32'(spi_miso), 32'd0);

        // Partial byte dropped by ss_n release, then a clean HID transaction.
        applyStimulus(mk(1'b1, 7, 8'h01, 8'h00, 4'b0000, 1'b0, 8'h00), "t4 target");
        c0 = strobe_cycles;
        send_bits(8'hF8, 5, 7, rx);
        ss_cycle();
        checkOutput("t4 partial pulses", 32'(strobe_cycles - c0), 32'd0);
        checkOutput("t4 partial miso",   32'(rx), 32'd0);
        applyStimulus(mk(1'b0, 7, 8'h01, 8'h00, 4'b0000, 1'b0, 8'h00), "t4 retarget");
        applyStimulus(mk(1'b0, 7, 8'hA5, 8'h00, 4'b0010, 1'b1, 8'hA5), "t4 data0");
        applyStimulus(mk(1'b0, 7, 8'h00, 8'h69, 4'b0010, 1'b0, 8'h00), "t4 data1");

        // Reset mid-byte with ss_n held low: the rest of that transaction must be ignored.
        applyStimulus(mk(1'b1, 7, 8'h00, 8'h00, 4'b0000, 1'b0, 8'h00), "t5 target");
        send_bits(8'hF0, 4, 7, rx);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t5 reset miso",    32'(spi_miso),  32'd0);
        checkOutput("t5 reset start",   32'(mcu_start), 32'd0);
        checkOutput("t5 reset dout",    32'(mcu_dout),  32'd0);
        checkOutput("t5 reset strobes", 32'(strobes),   32'd0);
        c0 = strobe_cycles;
        send_bits(8'h00, 4, 7, rx);
        checkOutput("t5 finish pulses", 32'(strobe_cycles - c0), 32'd0);
        applyStimulus(mk(1'b0, 7, 8'h11, 8'h00, 4'b0000, 1'b0, 8'h00), "t5 ignored0");
        applyStimulus(mk(1'b0, 7, 8'h22, 8'h00, 4'b0000, 1'b0, 8'h00), "t5 ignored1");
        applyStimulus(mk(1'b1, 7, 8'h00, 8'h00, 4'b0000, 1'b0, 8'h00), "t5 fresh target");
        applyStimulus(mk(1'b0, 7, 8'h5A, 8'h00, 4'b0001, 1'b1, 8'h5A), "t5 fresh data0");
        applyStimulus(mk(1'b0, 7, 8'h00, 8'hD2, 4'b0001, 1'b0, 8'h00), "t5 fresh data1");

        @(negedge clk);
        spi_ss_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
